// File: rtl/second_min_search.sv
// Scans the per-second amplitude BRAM and reports the slot holding the lowest
// accumulated carrier amplitude (the MSF carrier-off edge) as low_time.
//
// state  | meaning
// IDLE   | waiting for start; address, compare-valid flag and running min cleared
// READ   | issuing one BRAM address per cycle, 0..NUM_BINS-1
// DRAIN  | no new reads; waiting for the last read data to be compared
// FINISH | low_time/min_value updated, done pulsed
module second_min_search #(
   parameter int NUM_BINS   = 250,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  bram_en,
   output logic [7:0]            bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            low_time,
   output logic [DATA_WIDTH-1:0] min_value
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   localparam logic [7:0] LAST_ADDR = 8'(NUM_BINS - 1);

   state_t state, state_nxt;

   logic [RD_LATENCY-1:0]      pipe_vld;
   logic [RD_LATENCY-1:0][7:0] pipe_idx;

   logic                  have_min;
   logic [7:0]            run_idx;
   logic [DATA_WIDTH-1:0] run_val;

   logic                  take;
   logic                  early_pending;
   logic [7:0]            cand_idx;
   logic [DATA_WIDTH-1:0] cand_val;

   // Strictly-less replacement keeps the lowest index on ties.
   always_comb begin
      take     = pipe_vld[RD_LATENCY-1] && (!have_min || (bram_rdata < run_val));
      cand_idx = take ? pipe_idx[RD_LATENCY-1] : run_idx;
      cand_val = take ? bram_rdata : run_val;
      early_pending = 1'b0;
      for (int k = 0; k < RD_LATENCY - 1; k++) begin
         early_pending = early_pending | pipe_vld[k];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (bram_addr == LAST_ADDR) state_nxt = DRAIN;
         DRAIN:   if (!early_pending) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bram_en   <= 1'b0;
         bram_addr <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         low_time  <= 8'd0;
         min_value <= '0;
      end else begin
         state     <= state_nxt;
         bram_en   <= (state_nxt == READ);
         bram_addr <= (state == READ && state_nxt == READ) ? bram_addr + 8'd1 : 8'd0;
         busy      <= (state_nxt == READ) || (state_nxt == DRAIN);
         done      <= (state_nxt == FINISH);
         // The last sample is compared on the same edge, so publish the candidate.
         if (state_nxt == FINISH) begin
            low_time  <= cand_idx;
            min_value <= cand_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         pipe_idx <= '0;
      end else begin
         pipe_vld[0] <= bram_en;
         pipe_idx[0] <= bram_addr;
         for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_idx[k] <= pipe_idx[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_min <= 1'b0;
         run_idx  <= 8'd0;
         run_val  <= '0;
      end else if (state == IDLE) begin
         have_min <= 1'b0;
         run_idx  <= 8'd0;
         run_val  <= '0;
      end else if (pipe_vld[RD_LATENCY-1]) begin
         have_min <= 1'b1;
         run_idx  <= cand_idx;
         run_val  <= cand_val;
      end
   end

endmodule
